mac_fcs_check: RTL and testbench



---
 rtl/mac_fcs_check.sv | 140 ++++++++++++++
 tb/tb_mac_fcs_check.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_fcs_check.sv
// mac_fcs_check: RMII receive-side frame checker.
// Finds the SFD after a run of 01 preamble dibits, runs the reflected CRC-32
// over every dibit that follows it (FCS included), and reports the FCS
// residue check, the byte count and the length/alignment errors at end of frame.
// The FSM state is kept in the named signal 'state' so checkers can bind to it.
module mac_fcs_check #(
    parameter int PREAMBLE_MIN = 8,
    parameter int MIN_BYTES    = 64,
    parameter int MAX_BYTES    = 1522
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        crsdv,
    input  logic [1:0]  rxd,
    output logic        done,
    output logic        fcs_ok,
    output logic        len_err,
    output logic        align_err,
    output logic [10:0] byte_count
);

    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    // Fixed-width copies of the parameters so every comparison is width-matched.
    localparam logic [5:0]  PRE_MIN_W = 6'(PREAMBLE_MIN);
    localparam logic [11:0] MIN_B_W   = 12'(MIN_BYTES);
    localparam logic [11:0] MAX_B_W   = 12'(MAX_BYTES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_DATA,
        S_DROP,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [4:0]  pre_cnt;
    logic [12:0] dibits;
    logic [31:0] crc;
    logic        sfd_hit;
    logic [10:0] bytes_now;

    // One LSB-first step of the reflected CRC-32.
    function automatic logic [31:0] crc_bit(input logic [31:0] c, input logic b);
        crc_bit = (c >> 1) ^ ((c[0] ^ b) ? CRC_POLY : 32'h0);
    endfunction

    // The dibit counter saturates at 8191, so its upper 11 bits saturate at 2047.
    assign bytes_now = dibits[12:2];
    assign sfd_hit   = (state == S_PREAMBLE) && (state_nxt == S_DATA);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; DONE ignores its input sample and always returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (crsdv && rxd == 2'b01) state_nxt = S_PREAMBLE;
            end
            S_PREAMBLE: begin
                if (!crsdv) begin
                    state_nxt = S_IDLE;
                end else if (rxd == 2'b11) begin
                    state_nxt = ({1'b0, pre_cnt} >= PRE_MIN_W) ? S_DATA : S_DROP;
                end else if (rxd != 2'b01) begin
                    state_nxt = S_DROP;
                end
            end
            S_DATA: begin
                if (!crsdv) state_nxt = S_DONE;
            end
            S_DROP: begin
                if (!crsdv) state_nxt = S_IDLE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Preamble run length, saturating at 31; cleared outside the preamble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= 5'd0;
        end else if (state == S_IDLE) begin
            pre_cnt <= (crsdv && rxd == 2'b01) ? 5'd1 : 5'd0;
        end else if (state == S_PREAMBLE) begin
            if (crsdv && rxd == 2'b01 && pre_cnt != 5'd31) pre_cnt <= pre_cnt + 5'd1;
        end else begin
            pre_cnt <= 5'd0;
        end
    end

    // CRC and dibit counter: seeded at the SFD, advanced on every data dibit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc    <= CRC_INIT;
            dibits <= 13'd0;
        end else if (sfd_hit) begin
            crc    <= CRC_INIT;
            dibits <= 13'd0;
        end else if (state == S_DATA && crsdv) begin
            crc <= crc_bit(crc_bit(crc, rxd[0]), rxd[1]);
            if (dibits != 13'h1FFF) dibits <= dibits + 13'd1;
        end
    end

    // End-of-frame results: latched on the edge that raises done, held otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done       <= 1'b0;
            fcs_ok     <= 1'b0;
            len_err    <= 1'b0;
            align_err  <= 1'b0;
            byte_count <= 11'd0;
        end else begin
            done <= (state == S_DONE);
            if (state == S_DONE) begin
                byte_count <= bytes_now;
                align_err  <= (dibits[1:0] != 2'b00);
                len_err    <= ({1'b0, bytes_now} < MIN_B_W) || ({1'b0, bytes_now} > MAX_B_W);
                fcs_ok     <= (crc == CRC_RESIDUE);
            end
        end
    end

endmodule

// File: tb/tb_mac_fcs_check.sv
// tb_mac_fcs_check: directed scenarios for the RMII FCS checker.
module tb_mac_fcs_check;

    logic        clk = 1'b0;
    logic        rst;
    logic        crsdv;
    logic [1:0]  rxd;
    logic        done;
    logic        fcs_ok;
    logic        len_err;
    logic        align_err;
    logic [10:0] byte_count;

    int errors = 0;
    int checks = 0;

    // Pulses of done seen, with the results captured alongside each one.
    int          done_cnt = 0;
    logic        res_fcs [0:255];
    logic [10:0] res_bc  [0:255];
    logic        res_len [0:255];

    // Frame buffer: header, padded payload, FCS.
    logic [7:0] frm [0:127];
    int         frm_len;

    mac_fcs_check #(
        .PREAMBLE_MIN(8),
        .MIN_BYTES(64),
        .MAX_BYTES(1522)
    ) dut (
        .clk(clk),
        .rst(rst),
        .crsdv(crsdv),
        .rxd(rxd),
        .done(done),
        .fcs_ok(fcs_ok),
        .len_err(len_err),
        .align_err(align_err),
        .byte_count(byte_count)
    );

    // 50 MHz reference clock.
    always #10 clk = ~clk;

    // Done monitor, sampled 1 ns after each rising edge.
    always @(posedge clk) begin
        #1;
        if (done === 1'b1) begin
            if (done_cnt < 256) begin
                res_fcs[done_cnt] = fcs_ok;
                res_bc[done_cnt]  = byte_count;
                res_len[done_cnt] = len_err;
            end
            done_cnt++;
        end
    end

    // Build the 64-byte test frame: 60 bytes of header+padded payload, then FCS.
    task automatic build_frame(input logic [7:0] last_payload);
        logic [31:0] c;
        logic        fb;
        logic [7:0]  hdr [0:13];
        hdr = '{8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A,
                8'h02, 8'hAB, 8'hCD, 8'hEF, 8'h01, 8'h23,
                8'h88, 8'hB5};
        for (int i = 0; i < 14; i++) frm[i] = hdr[i];
        for (int i = 14; i < 60; i++) frm[i] = 8'h00;
        frm[18] = last_payload;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < 60; i++) begin
            for (int b = 0; b < 8; b++) begin
                fb = c[0] ^ frm[i][b];
                c  = (c >> 1) ^ (fb ? 32'hEDB8_8320 : 32'h0);
            end
        end
        c = ~c;
        frm[60] = c[7:0];
        frm[61] = c[15:8];
        frm[62] = c[23:16];
        frm[63] = c[31:24];
        frm_len = 64;
    endtask

    // Drive one RMII sample, updated on the falling edge.
    task automatic drive(input logic cv, input logic [1:0] d);
        @(negedge clk);
        crsdv = cv;
        rxd   = d;
    endtask

    task automatic send_preamble(input int n, input logic [1:0] sfd);
        for (int i = 0; i < n; i++) drive(1'b1, 2'b01);
        drive(1'b1, sfd);
    endtask

    // Bytes [from, to) of the frame buffer, LSB dibit first.
    task automatic send_bytes(input int from, input int to);
        for (int i = from; i < to; i++) begin
            for (int k = 0; k < 4; k++) drive(1'b1, frm[i][2*k +: 2]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 2'b00);
    endtask

    // Bounded wait for the done count to exceed base; no comparison here.
    task automatic wait_done(input int base, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 16 && !seen; i++) begin
            @(negedge clk);
            if (done_cnt > base) seen = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        crsdv = 1'b0;
        rxd = 2'b00;
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (fcs_ok !== 1'b0) begin errors++; $display("FAIL reset_fcs_ok: got %b want 0", fcs_ok); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err: got %b want 0", len_err); end
        checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL reset_align_err: got %b want 0", align_err); end
        checks++; if (byte_count !== 11'd0) begin errors++; $display("FAIL reset_byte_count: got %0d want 0", byte_count); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_good_frame;
        int base;
        bit seen;
        base = done_cnt;
        build_frame(8'h05);
        send_preamble(28, 2'b11);
        send_bytes(0, frm_len);
        idle(1);
        wait_done(base, seen);
        checks++; if (!seen) begin errors++; $display("FAIL good_done: got %0d pulses want 1", done_cnt - base); end
        checks++; if (fcs_ok !== 1'b1) begin errors++; $display("FAIL good_fcs_ok: got %b want 1", fcs_ok); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL good_len_err: got %b want 0", len_err); end
        checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL good_align_err: got %b want 0", align_err); end
        checks++; if (byte_count !== 11'd64) begin errors++; $display("FAIL good_byte_count: got %0d want 64", byte_count); end
        idle(4);
        checks++; if (done_cnt - base != 1) begin errors++; $display("FAIL good_single_done: got %0d pulses want 1", done_cnt - base); end
    endtask

    task automatic test_bad_fcs;
        int base;
        bit seen;
        base = done_cnt;
        build_frame(8'h05);
        frm[14] = frm[14] ^ 8'h01;
        send_preamble(28, 2'b11);
        send_bytes(0, frm_len);
        idle(1);
        wait_done(base, seen);
        checks++; if (!seen) begin errors++; $display("FAIL badfcs_done: got %0d pulses want 1", done_cnt - base); end
        checks++; if (fcs_ok !== 1'b0) begin errors++; $display("FAIL badfcs_fcs_ok: got %b want 0", fcs_ok); end
        checks++; if (byte_count !== 11'd64) begin errors++; $display("FAIL badfcs_byte_count: got %0d want 64", byte_count); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL badfcs_len_err: got %b want 0", len_err); end
        idle(4);
    endtask

    task automatic test_short_frame;
        int base;
        bit seen;
        base = done_cnt;
        build_frame(8'h05);
        send_preamble(28, 2'b11);
        send_bytes(0, 40);
        idle(1);
        wait_done(base, seen);
        checks++; if (!seen) begin errors++; $display("FAIL short_done: got %0d pulses want 1", done_cnt - base); end
        checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL short_len_err: got %b want 1", len_err); end
        checks++; if (byte_count !== 11'd40) begin errors++; $display("FAIL short_byte_count: got %0d want 40", byte_count); end
        checks++; if (fcs_ok !== 1'b0) begin errors++; $display("FAIL short_fcs_ok: got %b want 0", fcs_ok); end
        checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL short_align_err: got %b want 0", align_err); end
        idle(4);
    endtask

    task automatic test_align;
        int base;
        bit seen;
        base = done_cnt;
        build_frame(8'h05);
        send_preamble(28, 2'b11);
        send_bytes(0, frm_len);
        drive(1'b1, 2'b10);
        idle(1);
        wait_done(base, seen);
        checks++; if (!seen) begin errors++; $display("FAIL align_done: got %0d pulses want 1", done_cnt - base); end
        checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL align_align_err: got %b want 1", align_err); end
        checks++; if (byte_count !== 11'd64) begin errors++; $display("FAIL align_byte_count: got %0d want 64", byte_count); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL align_len_err: got %b want 0", len_err); end
        idle(4);
    endtask

    // Both frames must be dropped; results stay as the alignment test left them.
    task automatic test_bad_preamble;
        int base;
        base = done_cnt;
        build_frame(8'h05);
        send_preamble(4, 2'b11);
        send_bytes(0, frm_len);
        idle(2);
        for (int i = 0; i < 10; i++) drive(1'b1, 2'b01);
        drive(1'b1, 2'b00);
        send_preamble(12, 2'b11);
        send_bytes(0, frm_len);
        idle(20);
        checks++; if (done_cnt != base) begin errors++; $display("FAIL badpre_no_done: got %0d pulses want 0", done_cnt - base); end
        checks++; if (align_err !== 1'b1) begin errors++; $display("FAIL badpre_align_held: got %b want 1", align_err); end
        checks++; if (byte_count !== 11'd64) begin errors++; $display("FAIL badpre_byte_count_held: got %0d want 64", byte_count); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL badpre_len_held: got %b want 0", len_err); end
    endtask

    task automatic test_reset_back_to_back;
        int  base;
        int  n;
        bit  finished;
        base = done_cnt;
        build_frame(8'h42);
        send_preamble(28, 2'b11);
        send_bytes(0, 30);
        drive(1'b1, frm[30][1:0]);
        #1 rst = 1'b1;
        #1;
        checks++; if (byte_count !== 11'd0) begin errors++; $display("FAIL rstmid_byte_count: got %0d want 0", byte_count); end
        checks++; if (align_err !== 1'b0) begin errors++; $display("FAIL rstmid_align_err: got %b want 0", align_err); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b want 0", done); end
        @(negedge clk);
        rst = 1'b0;
        send_bytes(31, frm_len);
        idle(1);
        checks++; if (done_cnt != base) begin errors++; $display("FAIL rstmid_no_done: got %0d pulses want 0", done_cnt - base); end

        for (int p = 0; p < 32; p++) begin
            build_frame(8'(p));
            send_preamble(28, 2'b11);
            send_bytes(0, frm_len);
            idle(1);
        end
        finished = 1'b0;
        for (int i = 0; i < 40 && !finished; i++) begin
            @(negedge clk);
            if (done_cnt >= base + 32) finished = 1'b1;
        end
        idle(4);
        n = done_cnt - base;
        checks++; if (n != 32) begin errors++; $display("FAIL b2b_done_count: got %0d pulses want 32", n); end
        if (n > 32) n = 32;
        for (int i = 0; i < n; i++) begin
            checks++; if (res_fcs[base+i] !== 1'b1) begin errors++; $display("FAIL b2b_fcs_ok[%0d]: got %b want 1", i, res_fcs[base+i]); end
            checks++; if (res_bc[base+i] !== 11'd64) begin errors++; $display("FAIL b2b_byte_count[%0d]: got %0d want 64", i, res_bc[base+i]); end
            checks++; if (res_len[base+i] !== 1'b0) begin errors++; $display("FAIL b2b_len_err[%0d]: got %b want 0", i, res_len[base+i]); end
        end
    endtask

    initial begin
        rst   = 1'b1;
        crsdv = 1'b0;
        rxd   = 2'b00;
        test_reset();
        test_good_frame();
        test_bad_fcs();
        test_short_frame();
        test_align();
        test_bad_preamble();
        test_reset_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "time limit");
    end

endmodule
